// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor front end.
// Holds the fetch FSM state encoding and the fetch sizing constants.
package simple_processor_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int DATA_WIDTH  = 32;
  localparam int PC_STEP     = 2;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    STALL,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} entries.
// Flush empties it in one cycle; the head is read straight from storage.
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: walks the PC, issues single-outstanding memory
// requests and queues returned instructions for decode, with redirect support.
module imem_fetch_unit
  import simple_processor_pkg::*;
#(
  parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int DEPTH      = FETCH_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  imem_ack_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;

  fetch_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [ADDR_WIDTH-1:0] target, target_next;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_after_push;
  logic [EW-1:0]         head;

  assign pop              = !empty && instr_ready_i;
  assign count_after_push = count + CW'(1) - CW'(pop);
  assign imem_addr_o      = pc;
  assign instr_valid_o    = !empty;
  assign instr_o          = head[ADDR_WIDTH +: DATA_WIDTH];
  assign instr_pc_o       = head[ADDR_WIDTH-1:0];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state  <= BOOT;
      pc     <= '0;
      target <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      target <= target_next;
    end
  end

  // pc keeps the address of the outstanding request while draining; the
  // redirect target waits in its own register until the stale ack returns.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    target_next = target;
    push        = 1'b0;
    flush       = 1'b0;
    imem_req_o  = 1'b0;
    case (state)
      BOOT: begin
        pc_next    = boot_addr_i;
        state_next = FETCH;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          flush = 1'b1;
          if (imem_ack_i) begin
            pc_next    = redirect_addr_i;
            state_next = FETCH;
          end else begin
            target_next = redirect_addr_i;
            state_next  = DRAIN;
          end
        end else if (imem_ack_i && !full) begin
          push       = 1'b1;
          pc_next    = pc + ADDR_WIDTH'(PC_STEP);
          state_next = (count_after_push == CW'(DEPTH)) ? STALL : FETCH;
        end
      end
      STALL: begin
        if (redirect_i) begin
          flush      = 1'b1;
          pc_next    = redirect_addr_i;
          state_next = FETCH;
        end else if (pop || !full) begin
          state_next = FETCH;
        end
      end
      DRAIN: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          flush       = 1'b1;
          target_next = redirect_addr_i;
        end
        if (imem_ack_i) begin
          pc_next    = redirect_i ? redirect_addr_i : target;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .flush   (flush),
    .push    (push),
    .data_in ({imem_rdata_i, pc}),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head)
  );

endmodule
